// File: rtl/sdram_port_arb_if.sv
// sdram_port_arb_if: requester (loader/CPU/video) and SDRAM controller signals of the port arbiter.
interface sdram_port_arb_if #(parameter int ADDR_W = 25);
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_din;
  logic              ld_ack;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_din;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_dout;
  logic              cpu_ack;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [31:0]       vid_dout;
  logic              vid_ack;
  logic [ADDR_W-1:0] sd_raddr;
  logic [ADDR_W-1:0] sd_waddr;
  logic [31:0]       sd_din;
  logic [3:0]        sd_be;
  logic              sd_rd;
  logic              sd_we;
  logic              sd_rd_rdy;
  logic              sd_we_rdy;
  logic [31:0]       sd_dout;
  logic              err;
  modport slave (
    input  ld_req, ld_addr, ld_din, cpu_req, cpu_we, cpu_addr, cpu_din, cpu_be,
           vid_req, vid_addr, sd_rd_rdy, sd_we_rdy, sd_dout,
    output ld_ack, cpu_dout, cpu_ack, vid_dout, vid_ack,
           sd_raddr, sd_waddr, sd_din, sd_be, sd_rd, sd_we, err
  );
  modport master (
    output ld_req, ld_addr, ld_din, cpu_req, cpu_we, cpu_addr, cpu_din, cpu_be,
           vid_req, vid_addr, sd_rd_rdy, sd_we_rdy, sd_dout,
    input  ld_ack, cpu_dout, cpu_ack, vid_dout, vid_ack,
           sd_raddr, sd_waddr, sd_din, sd_be, sd_rd, sd_we, err
  );
endinterface

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: shares one SDRAM controller port between loader (top priority), CPU and video (round-robin).
module sdram_port_arb #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  sdram_port_arb_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT, DONE} state_t;
  typedef enum logic [1:0] {G_LD, G_CPU, G_VID} gnt_t;
  state_t            state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  logic              last_vid_q, last_vid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [3:0]        be_q, be_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       cpu_dout_q, cpu_dout_d;
  logic [31:0]       vid_dout_q, vid_dout_d;
  logic [CW-1:0]     cnt_inc;
  logic              rdy, timeout;
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = cnt_inc == TO_CNT;
  assign rdy     = we_q ? bus.sd_we_rdy : bus.sd_rd_rdy;
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_vid_d = last_vid_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    cpu_dout_d = cpu_dout_q;
    vid_dout_d = vid_dout_q;
    case (state_q)
      IDLE: if ((bus.ld_req || bus.cpu_req || bus.vid_req) && bus.sd_rd_rdy && bus.sd_we_rdy) begin
        state_d    = ISSUE;
        gnt_d      = bus.ld_req ? G_LD : (bus.cpu_req && (!bus.vid_req || last_vid_q)) ? G_CPU : G_VID;
        // loader grants leave the CPU/video rotation untouched
        last_vid_d = bus.ld_req ? last_vid_q : gnt_d == G_VID;
        we_d       = gnt_d == G_LD || (gnt_d == G_CPU && bus.cpu_we);
        addr_d     = gnt_d == G_LD ? bus.ld_addr : gnt_d == G_CPU ? bus.cpu_addr : bus.vid_addr;
        din_d      = gnt_d == G_LD ? bus.ld_din : gnt_d == G_CPU ? bus.cpu_din : '0;
        be_d       = gnt_d == G_CPU ? bus.cpu_be : 4'hF;
      end
      ISSUE: state_d = HOLD;
      HOLD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (rdy || timeout) begin
          state_d = DONE;
          err_d   = err_q | ~rdy;
          if (!we_q && gnt_q == G_CPU) cpu_dout_d = rdy ? bus.sd_dout : '0;
          if (!we_q && gnt_q == G_VID) vid_dout_d = rdy ? bus.sd_dout : '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= G_LD;
      last_vid_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      be_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      cpu_dout_q <= '0;
      vid_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_vid_q <= last_vid_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      cpu_dout_q <= cpu_dout_d;
      vid_dout_q <= vid_dout_d;
    end
  end
  assign bus.sd_rd    = state_q == ISSUE && !we_q;
  assign bus.sd_we    = state_q == ISSUE && we_q;
  assign bus.ld_ack   = state_q == DONE && gnt_q == G_LD;
  assign bus.cpu_ack  = state_q == DONE && gnt_q == G_CPU;
  assign bus.vid_ack  = state_q == DONE && gnt_q == G_VID;
  assign bus.sd_raddr = addr_q;
  assign bus.sd_waddr = addr_q;
  assign bus.sd_din   = din_q;
  assign bus.sd_be    = be_q;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.vid_dout = vid_dout_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: directed stimulus with a strobe/ack scoreboard against a behavioural SDRAM controller.
module tb_sdram_port_arb;
  localparam int AW = 25;
  localparam int TO = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sdram_port_arb_if #(.ADDR_W(AW)) bus();
  sdram_port_arb #(.ADDR_W(AW), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [3:0]    be;
    logic          chk_be;
    int            gap;
  } strobe_t;
  typedef struct {
    int          port;
    logic [31:0] cpu;
    logic [31:0] vid;
    logic        err;
    int          lat;
  } ack_t;
  strobe_t sq[$];
  ack_t    aq[$];
  strobe_t ms;
  ack_t    ma;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strobe = -100;
  int busy = 0;
  bit hang = 1'b0;
  int ccnt = 0;
  int rel;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] f(input logic [AW-1:0] a);
    return (a == 25'h100) ? 32'hDEADBEEF : ({7'd0, a} ^ 32'hC0DE_0000);
  endfunction
  task automatic push_s(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic cb, input int gap);
    strobe_t s;
    s.we = we; s.addr = a; s.din = d; s.be = be; s.chk_be = cb; s.gap = gap;
    sq.push_back(s);
  endtask
  task automatic push_a(input int p, input logic [31:0] c, input logic [31:0] v,
                        input logic e, input int lat);
    ack_t x;
    x.port = p; x.cpu = c; x.vid = v; x.err = e; x.lat = lat;
    aq.push_back(x);
  endtask
  // SDRAM controller model: both readies drop after a strobe for busy cycles, forever while hang
  initial begin
    bus.sd_rd_rdy = 1'b1;
    bus.sd_we_rdy = 1'b1;
    bus.sd_dout   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.sd_rd_rdy = 1'b1; bus.sd_we_rdy = 1'b1; ccnt = 0;
      end else if (bus.sd_rd || bus.sd_we) begin
        bus.sd_dout = f(bus.sd_raddr);
        if (busy > 0 || hang) begin
          bus.sd_rd_rdy = 1'b0; bus.sd_we_rdy = 1'b0; ccnt = busy;
        end
      end else if (!hang && ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) begin bus.sd_rd_rdy = 1'b1; bus.sd_we_rdy = 1'b1; end
      end else if (!hang) begin
        bus.sd_rd_rdy = 1'b1; bus.sd_we_rdy = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (bus.sd_rd || bus.sd_we) begin
      chk("strobe_exclusive", {31'd0, bus.sd_rd & bus.sd_we}, 32'd0);
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got rd=%b we=%b expected none", bus.sd_rd, bus.sd_we);
      end else begin
        ms = sq.pop_front();
        chk("strobe_dir", {31'd0, bus.sd_we}, {31'd0, ms.we});
        chk("strobe_addr", {7'd0, ms.we ? bus.sd_waddr : bus.sd_raddr}, {7'd0, ms.addr});
        if (ms.we) chk("strobe_din", bus.sd_din, ms.din);
        if (ms.chk_be) chk("strobe_be", {28'd0, bus.sd_be}, {28'd0, ms.be});
        if (ms.gap >= 0) chk("strobe_gap", cyc - last_strobe, ms.gap);
      end
      last_strobe = cyc;
    end
    if (bus.ld_ack || bus.cpu_ack || bus.vid_ack) begin
      chk("ack_onehot", 32'(bus.ld_ack) + 32'(bus.cpu_ack) + 32'(bus.vid_ack), 32'd1);
      if (aq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ld=%b cpu=%b vid=%b expected none", bus.ld_ack, bus.cpu_ack, bus.vid_ack);
      end else begin
        ma = aq.pop_front();
        chk("ack_port", bus.ld_ack ? 0 : bus.cpu_ack ? 1 : 2, ma.port);
        chk("ack_cpu_dout", bus.cpu_dout, ma.cpu);
        chk("ack_vid_dout", bus.vid_dout, ma.vid);
        chk("ack_err", {31'd0, bus.err}, {31'd0, ma.err});
        if (ma.lat >= 0) chk("ack_latency", cyc - last_strobe, ma.lat);
      end
    end
  end
  task automatic wait_ack(input int p);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (p == 0 ? bus.ld_ack : p == 1 ? bus.cpu_ack : bus.vid_ack) return;
    end
    checks++; errors++;
    $display("FAIL ack_wait port %0d: got no ack in 400 cycles expected one", p);
  endtask
  task automatic cpu_go(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int n);
    bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_be = be; bus.cpu_req = 1'b1;
    repeat (n) wait_ack(1);
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
  endtask
  task automatic vid_go(input logic [AW-1:0] a, input int n);
    bus.vid_addr = a; bus.vid_req = 1'b1;
    repeat (n) wait_ack(2);
    @(posedge clk);
    #1 bus.vid_req = 1'b0;
  endtask
  task automatic ld_go(input logic [AW-1:0] a, input logic [31:0] d);
    bus.ld_addr = a; bus.ld_din = d; bus.ld_req = 1'b1;
    wait_ack(0);
    @(posedge clk);
    #1 bus.ld_req = 1'b0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ld_ack"}, {31'd0, bus.ld_ack}, 32'd0);
    chk({tag, "_cpu_ack"}, {31'd0, bus.cpu_ack}, 32'd0);
    chk({tag, "_vid_ack"}, {31'd0, bus.vid_ack}, 32'd0);
    chk({tag, "_sd_rd"}, {31'd0, bus.sd_rd}, 32'd0);
    chk({tag, "_sd_we"}, {31'd0, bus.sd_we}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    chk({tag, "_cpu_dout"}, bus.cpu_dout, 32'd0);
    chk({tag, "_vid_dout"}, bus.vid_dout, 32'd0);
    chk({tag, "_sd_raddr"}, {7'd0, bus.sd_raddr}, 32'd0);
    chk({tag, "_sd_waddr"}, {7'd0, bus.sd_waddr}, 32'd0);
    chk({tag, "_sd_din"}, bus.sd_din, 32'd0);
    chk({tag, "_sd_be"}, {28'd0, bus.sd_be}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end
  initial begin
    bus.ld_req = 0; bus.ld_addr = '0; bus.ld_din = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0; bus.cpu_be = '0;
    bus.vid_req = 0; bus.vid_addr = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;
    // single CPU read with a busy controller
    busy = 3;
    push_s(0, 25'h100, 32'h0, 4'hF, 1, -1);
    push_a(1, 32'hDEADBEEF, 32'h0, 0, -1);
    cpu_go(0, 25'h100, 32'h0, 4'hF, 1);
    // CPU partial write leaves read data alone
    busy = 2;
    push_s(1, 25'h200, 32'h12345678, 4'b0011, 1, -1);
    push_a(1, 32'hDEADBEEF, 32'h0, 0, -1);
    cpu_go(1, 25'h200, 32'h12345678, 4'b0011, 1);
    // fresh reset so the first tie goes to the CPU, then six back-to-back tie accesses
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      push_s(0, 25'h300, 32'h0, 4'hF, 1, i == 0 ? -1 : 5);
      push_a(1, f(25'h300), i == 0 ? 32'h0 : f(25'h400), 0, 3);
      push_s(0, 25'h400, 32'h0, 4'hF, 0, 5);
      push_a(2, f(25'h300), f(25'h400), 0, 3);
    end
    fork
      cpu_go(0, 25'h300, 32'h0, 4'hF, 3);
      vid_go(25'h400, 3);
    join
    // loader arrives while video waits; it beats the pending CPU, rotation is unchanged
    busy = 4;
    push_s(0, 25'h500, 32'h0, 4'hF, 0, -1);
    push_a(2, f(25'h300), f(25'h500), 0, -1);
    push_s(1, 25'h600, 32'hCAFEF00D, 4'hF, 1, -1);
    push_a(0, f(25'h300), f(25'h500), 0, -1);
    push_s(0, 25'h700, 32'h0, 4'b1010, 1, -1);
    push_a(1, f(25'h700), f(25'h500), 0, -1);
    push_s(0, 25'h500, 32'h0, 4'hF, 0, -1);
    push_a(2, f(25'h700), f(25'h500), 0, -1);
    fork
      vid_go(25'h500, 2);
      begin
        repeat (3) @(posedge clk);
        #1;
        fork
          ld_go(25'h600, 32'hCAFEF00D);
          cpu_go(0, 25'h700, 32'h0, 4'b1010, 1);
        join
      end
    join
    // controller hangs after a video read strobe: abort after TIMEOUT wait cycles
    hang = 1'b1;
    busy = 1;
    push_s(0, 25'h800, 32'h0, 4'hF, 0, -1);
    push_a(2, f(25'h700), 32'h0, 1, TO + 2);
    vid_go(25'h800, 1);
    hang = 1'b0;
    busy = 0;
    repeat (3) @(posedge clk);
    #1 chk("err_sticky", {31'd0, bus.err}, 32'd1);
    push_s(1, 25'h900, 32'h55AA55AA, 4'b1100, 1, -1);
    push_a(1, f(25'h700), 32'h0, 1, 3);
    cpu_go(1, 25'h900, 32'h55AA55AA, 4'b1100, 1);
    chk("err_sticky_after_cpu", {31'd0, bus.err}, 32'd1);
    // reset during HOLD of a CPU write; the held request is serviced afresh
    push_s(1, 25'hA00, 32'h0BADF00D, 4'hF, 1, -1);
    push_s(1, 25'hA00, 32'h0BADF00D, 4'hF, 1, -1);
    push_a(1, 32'h0, 32'h0, 0, 3);
    fork
      cpu_go(1, 25'hA00, 32'h0BADF00D, 4'hF, 1);
      begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        rel = cyc;
        wait_ack(1);
        chk("rerequest_latency", cyc - rel, 4);
      end
    join
    repeat (5) @(posedge clk);
    chk("strobe_queue_empty", sq.size(), 0);
    chk("ack_queue_empty", aq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
